// File: rtl/foo_sink_pkg.sv
// Shared types and constants for the foo sink tracker.
package foo_sink_pkg;

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      DONE
   } tracker_state_t;

   // Width of the consecutive-mismatch counter; MAX_MISS must fit in it.
   localparam int MISS_W = 4;

endpackage

// File: rtl/foo_intf.sv
// Single-bit link carried by each element of the foo interface array.
interface foo_intf;
   logic a;

   modport source (output a);
   modport sink   (input  a);
endinterface

// File: rtl/foo_sat_cnt.sv
// Saturating up-counter with synchronous reset and clear.
module foo_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   // Clear wins over increment; increment stops at all ones.
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc && (q_q != {W{1'b1}})) begin
         q_d = q_q + W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/foo_sink_tracker.sv
// Receive-side tracker: checks that the word gathered from the interface
// array increments by one each cycle, and reports lock, counts and completion.
module foo_sink_tracker #(
   parameter int N        = 1,
   parameter int CNT_W    = 16,
   parameter int MAX_MISS = 3
) (
   input  logic             clk,
   input  logic             rst,
   foo_intf.sink            foos [N-1:0],
   input  logic             en,
   input  logic             clr,
   output logic             locked,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [N-1:0]     last_rx
);
   import foo_sink_pkg::*;

   logic [N-1:0]      rx;
   tracker_state_t    state_q, state_d;
   logic [N-1:0]      exp_q, exp_d;
   logic [MISS_W-1:0] miss_q, miss_d;
   logic              locked_q, done_q;
   logic [N-1:0]      last_rx_q;
   logic              match_inc, err_inc;

   for (genvar i = 0; i < N; i++) begin : g_rx
      assign rx[i] = foos[i].a;
   end

   // Next-state, expected word and mismatch run; every scored word resyncs exp.
   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      miss_d    = miss_q;
      match_inc = 1'b0;
      err_inc   = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               exp_d   = rx + N'(1);
               miss_d  = '0;
               state_d = TRACK;
            end
         end
         TRACK: begin
            if (!en) begin
               state_d = IDLE;
            end else if (rx == exp_q) begin
               match_inc = 1'b1;
               miss_d    = '0;
               exp_d     = rx + N'(1);
               if (rx == {N{1'b1}}) begin
                  state_d = DONE;
               end
            end else begin
               err_inc = 1'b1;
               miss_d  = miss_q + MISS_W'(1);
               exp_d   = rx + N'(1);
               if ((miss_q + MISS_W'(1)) == MISS_W'(MAX_MISS)) begin
                  state_d = IDLE;
               end
            end
         end
         DONE: begin
            if (clr) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Tracker state plus registered status outputs derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         exp_q     <= '0;
         miss_q    <= '0;
         locked_q  <= 1'b0;
         done_q    <= 1'b0;
         last_rx_q <= '0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         miss_q    <= miss_d;
         locked_q  <= (state_d == TRACK);
         done_q    <= (state_d == DONE);
         last_rx_q <= rx;
      end
   end

   foo_sat_cnt #(.W(CNT_W)) u_match_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (match_inc),
      .q   (match_cnt)
   );

   foo_sat_cnt #(.W(CNT_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (err_inc),
      .q   (err_cnt)
   );

   assign locked  = locked_q;
   assign done    = done_q;
   assign last_rx = last_rx_q;

endmodule

// File: tb/tb_foo_sink_tracker.sv
// Bench for foo_sink_tracker: three instances (N=1; N=4; N=8 with 2-bit
// counters) driven in lockstep, scored against a behavioural model through
// a queue, plus directed checks of the key scenarios.
module tb_foo_sink_tracker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       e1 = 1'b0, c1 = 1'b0;
   logic [0:0] s1 = '0;
   logic       e4 = 1'b0, c4 = 1'b0;
   logic [3:0] s4 = '0;
   logic       e8 = 1'b0, c8 = 1'b0;
   logic [7:0] s8 = '0;

   foo_intf if1 [0:0] ();
   foo_intf if4 [3:0] ();
   foo_intf if8 [7:0] ();

   for (genvar i = 0; i < 1; i++) begin : g_d1
      assign if1[i].a = s1[i];
   end
   for (genvar i = 0; i < 4; i++) begin : g_d4
      assign if4[i].a = s4[i];
   end
   for (genvar i = 0; i < 8; i++) begin : g_d8
      assign if8[i].a = s8[i];
   end

   logic        l1, d1, l4, d4, l8, d8;
   logic [15:0] m1, er1, m4, er4;
   logic [1:0]  m8, er8;
   logic [0:0]  lr1;
   logic [3:0]  lr4;
   logic [7:0]  lr8;

   foo_sink_tracker #(.N(1), .CNT_W(16), .MAX_MISS(3)) u_dut1 (
      .clk(clk), .rst(rst), .foos(if1), .en(e1), .clr(c1),
      .locked(l1), .done(d1), .match_cnt(m1), .err_cnt(er1), .last_rx(lr1));

   foo_sink_tracker #(.N(4), .CNT_W(16), .MAX_MISS(3)) u_dut4 (
      .clk(clk), .rst(rst), .foos(if4), .en(e4), .clr(c4),
      .locked(l4), .done(d4), .match_cnt(m4), .err_cnt(er4), .last_rx(lr4));

   foo_sink_tracker #(.N(8), .CNT_W(2), .MAX_MISS(3)) u_dut8 (
      .clk(clk), .rst(rst), .foos(if8), .en(e8), .clr(c8),
      .locked(l8), .done(d8), .match_cnt(m8), .err_cnt(er8), .last_rx(lr8));

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          id;
      logic        lk;
      logic        dn;
      logic [31:0] mc;
      logic [31:0] ec;
      logic [31:0] lr;
   } exp_t;
   exp_t sb[$];

   // model state, index = instance (0:N=1, 1:N=4, 2:N=8)
   int          nw [3] = '{1, 4, 8};
   int          cw [3] = '{16, 16, 2};
   int          mm [3] = '{3, 3, 3};
   int          m_st [3];   // 0 idle, 1 track, 2 done
   int unsigned m_exp [3];
   int unsigned m_miss [3];
   int unsigned m_mc [3];
   int unsigned m_ec [3];
   int unsigned m_lr [3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model(input int id, input logic e, input logic c, input int unsigned rx);
      int unsigned mask;
      int unsigned maxc;
      bit          inc_m;
      bit          inc_e;
      exp_t        x;
      mask  = (32'd1 << nw[id]) - 1;
      maxc  = (32'd1 << cw[id]) - 1;
      inc_m = 0;
      inc_e = 0;
      if (rst) begin
         m_st[id] = 0; m_exp[id] = 0; m_miss[id] = 0;
         m_mc[id] = 0; m_ec[id] = 0; m_lr[id] = 0;
      end else begin
         m_lr[id] = rx;
         if (m_st[id] == 0) begin
            if (e) begin
               m_exp[id] = (rx + 1) & mask;
               m_miss[id] = 0;
               m_st[id] = 1;
            end
         end else if (m_st[id] == 1) begin
            if (!e) begin
               m_st[id] = 0;
            end else if (rx == m_exp[id]) begin
               inc_m = 1;
               m_miss[id] = 0;
               m_exp[id] = (rx + 1) & mask;
               if (rx == mask) m_st[id] = 2;
            end else begin
               inc_e = 1;
               m_exp[id] = (rx + 1) & mask;
               if (m_miss[id] + 1 == mm[id]) m_st[id] = 0;
               m_miss[id] = m_miss[id] + 1;
            end
         end else begin
            if (c) m_st[id] = 0;
         end
         if (c) begin
            m_mc[id] = 0;
            m_ec[id] = 0;
         end else begin
            if (inc_m && m_mc[id] < maxc) m_mc[id] = m_mc[id] + 1;
            if (inc_e && m_ec[id] < maxc) m_ec[id] = m_ec[id] + 1;
         end
      end
      x.id = id;
      x.lk = (m_st[id] == 1);
      x.dn = (m_st[id] == 2);
      x.mc = m_mc[id];
      x.ec = m_ec[id];
      x.lr = m_lr[id];
      sb.push_back(x);
   endtask

   // One clock: predict all instances, clock, then compare each prediction.
   task automatic tick();
      exp_t        x;
      logic        a_l, a_d;
      logic [31:0] a_m, a_e, a_x;
      model(0, e1, c1, 32'(s1));
      model(1, e4, c4, 32'(s4));
      model(2, e8, c8, 32'(s8));
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         case (x.id)
            0:       begin a_l = l1; a_d = d1; a_m = 32'(m1); a_e = 32'(er1); a_x = 32'(lr1); end
            1:       begin a_l = l4; a_d = d4; a_m = 32'(m4); a_e = 32'(er4); a_x = 32'(lr4); end
            default: begin a_l = l8; a_d = d8; a_m = 32'(m8); a_e = 32'(er8); a_x = 32'(lr8); end
         endcase
         chk($sformatf("sb%0d_locked", x.id), 32'(a_l), 32'(x.lk));
         chk($sformatf("sb%0d_done", x.id), 32'(a_d), 32'(x.dn));
         chk($sformatf("sb%0d_match_cnt", x.id), a_m, x.mc);
         chk($sformatf("sb%0d_err_cnt", x.id), a_e, x.ec);
         chk($sformatf("sb%0d_last_rx", x.id), a_x, x.lr);
      end
   endtask

   task automatic feed1(input logic [0:0] v); e1 = 1'b1; s1 = v; tick(); endtask
   task automatic feed4(input logic [3:0] v); e4 = 1'b1; s4 = v; tick(); endtask
   task automatic feed8(input logic [7:0] v); e8 = 1'b1; s8 = v; tick(); endtask

   initial begin
      // reset
      rst = 1'b1;
      tick();
      tick();
      chk("rst_locked4", 32'(l4), 0);
      chk("rst_done4", 32'(d4), 0);
      chk("rst_match4", 32'(m4), 0);
      rst = 1'b0;

      // N=1 toggle 0,1,0,1
      feed1(1'b0);
      chk("n1_locked_e1", 32'(l1), 1);
      feed1(1'b1);
      chk("n1_done_e2", 32'(d1), 1);
      feed1(1'b0);
      feed1(1'b1);
      chk("n1_match", 32'(m1), 1);
      chk("n1_err", 32'(er1), 0);
      chk("n1_still_done", 32'(d1), 1);
      e1 = 1'b0;

      // N=4 count 5..15
      for (int v = 5; v <= 15; v++) feed4(4'(v));
      chk("n4_done", 32'(d4), 1);
      chk("n4_match10", 32'(m4), 10);
      chk("n4_err0", 32'(er4), 0);
      chk("n4_last15", 32'(lr4), 15);

      // clr in DONE, then re-lock
      c4 = 1'b1; s4 = 4'd0; tick(); c4 = 1'b0;
      chk("clr_done", 32'(d4), 0);
      chk("clr_match", 32'(m4), 0);
      chk("clr_idle", 32'(l4), 0);
      feed4(4'd2);
      chk("relock", 32'(l4), 1);

      // miss run 2,3,9,0,7,12
      feed4(4'd3);
      feed4(4'd9);
      feed4(4'd0);
      chk("miss_still_locked", 32'(l4), 1);
      feed4(4'd7);
      chk("miss_unlock", 32'(l4), 0);
      chk("miss_err3", 32'(er4), 3);
      chk("miss_match1", 32'(m4), 1);
      feed4(4'd12);

      // single skip 2,3,5,6
      e4 = 1'b0; c4 = 1'b1; tick(); c4 = 1'b0;
      feed4(4'd2);
      feed4(4'd3);
      feed4(4'd5);
      feed4(4'd6);
      chk("skip_match2", 32'(m4), 2);
      chk("skip_err1", 32'(er4), 1);
      chk("skip_locked", 32'(l4), 1);

      // exp wraps 15 -> 0 after a resync on 15
      feed4(4'd15);
      feed4(4'd0);
      chk("wrap_match", 32'(m4), 3);
      chk("wrap_err", 32'(er4), 2);

      // clr during a match: not counted, lock kept
      c4 = 1'b1; feed4(4'd1); c4 = 1'b0;
      chk("clrm_match0", 32'(m4), 0);
      chk("clrm_locked", 32'(l4), 1);

      // rst mid-TRACK with match_cnt=4
      feed4(4'd2); feed4(4'd3); feed4(4'd4); feed4(4'd5);
      chk("pre_rst_match4", 32'(m4), 4);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid_rst_locked", 32'(l4), 0);
      chk("mid_rst_match", 32'(m4), 0);
      chk("mid_rst_last", 32'(lr4), 0);

      // en falls with an all-ones match
      feed4(4'd14);
      e4 = 1'b0; s4 = 4'd15; tick();
      chk("enfall_done", 32'(d4), 0);
      chk("enfall_locked", 32'(l4), 0);
      chk("enfall_match", 32'(m4), 0);

      // N=8, CNT_W=2 saturation
      for (int v = 0; v <= 10; v++) feed8(8'(v));
      chk("sat_match3", 32'(m8), 3);
      chk("sat_err0", 32'(er8), 0);

      // mixed traffic on all instances
      for (int k = 0; k < 60; k++) begin
         e1 = ($urandom_range(0, 7) != 0);
         e4 = ($urandom_range(0, 7) != 0);
         e8 = ($urandom_range(0, 7) != 0);
         c1 = ($urandom_range(0, 11) == 0);
         c4 = ($urandom_range(0, 11) == 0);
         c8 = ($urandom_range(0, 11) == 0);
         s1 = ($urandom_range(0, 3) == 0) ? 1'($urandom) : ~s1;
         s4 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : s4 + 4'd1;
         s8 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : s8 + 8'd1;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
